shift_rotate: RTL and testbench
===============================

// Module: shift_rotate
// PURPOSE
//   8-bit barrel shifter/rotator for the datapath ALU.
//   Applies one of four shift/rotate operations by 0..7 positions to a data byte.
//   Registers the result, a carry-out bit and a zero flag one clock after the inputs are sampled.
//   Sits beside the arithmetic unit; the result mux selects its output for shift/rotate instructions.
// PARAMETERS
//   WIDTH    8   data width; must be 8 (the shiftCount width is fixed at 3)
//   CNT_W    3   shift-count width, log2(WIDTH)
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   in_valid    in   1      qualifies shiftCount/data/operation this cycle
//   shiftCount  in   3      shift/rotate amount, 0..7
//   data        in   8      operand
//   operation   in   2      00 SLL, 01 SRL, 10 ROL, 11 ROR
//   result      out  8      registered shifted/rotated value
//   carry_out   out  1      last bit shifted/rotated out (see below)
//   zero        out  1      result == 0
//   out_valid   out  1      result/carry_out/zero updated this cycle
// BEHAVIOUR
//   Reset (rst=1 at posedge clk)
//   - result=8'h00, carry_out=0, zero=1, out_valid=0.
//   - rst has priority over in_valid.
//   Latency and valid handling
//   - Latency is exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N.
//   - out_valid = in_valid registered.
//   - When in_valid=0, result/carry_out/zero hold their previous values. No backpressure.
//   Operations (n = shiftCount)
//   - 00 SLL: data << n, zero fill. carry = data[8-n] for n>0.
//   - 01 SRL: data >> n, zero fill. carry = data[n-1] for n>0.
//   - 10 ROL: (data << n) | (data >> (8-n)). carry = result[0] for n>0.
//   - 11 ROR: (data >> n) | (data << (8-n)). carry = result[7] for n>0.
//   Count = 0
//   - result = data for all operations; carry_out = 0.
//   Width and flag rules
//   - No sign extension anywhere; all intermediates truncated to 8 bits.
//   - zero is computed from the new result, in the same cycle result updates.
//   Timing
//   - Combinational core is a 3-stage mux barrel (stages 1/2/4) feeding the output registers.
//   - Inputs may change every cycle; back-to-back valid inputs give back-to-back results.
// TESTING
//   - Reset: rst=1 for 2 cycles -> result=00, zero=1, carry_out=0, out_valid=0.
//   - SLL: data=05, n=2, op=00 -> result=14, carry_out=0.
//     n=3 -> result=28, carry_out=0. zero=0 in both cases.
//   - SRL: data=64, n=3, op=01 -> result=0C, carry_out=1.
//     data=01, n=1 -> result=00, zero=1, carry_out=1.
//   - ROL: data=64, n=3, op=10 -> result=23, carry_out=1.
//     data=86, n=3 -> result=34, carry_out=0.
//   - ROR: data=86, n=3, op=11 -> result=D0, carry_out=1.
//     n=0, any op, data=A5 -> result=A5, carry_out=0.
//   - Stream and reset interaction:
//     back-to-back in_valid with changing op -> one result per cycle, each 1 cycle late.
//     in_valid=0 -> outputs held.
//     rst asserted mid-stream -> outputs clear at the next edge.

Source files
------------

// File: rtl/shift_rotate.sv
// 8-bit registered barrel shifter/rotator (SLL, SRL, ROL, ROR by 0..7).
// Result, carry-out and zero flag appear one clock after a valid input.
module shift_rotate #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] shiftCount,
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    // Logical shifts carry one guard bit so the last bit shifted out falls into it.
    logic [WIDTH:0]   sll_0, sll_1, sll_2, sll_3;
    logic [WIDTH:0]   srl_0, srl_1, srl_2, srl_3;
    logic [WIDTH-1:0] rol_0, rol_1, rol_2, rol_3;
    logic [WIDTH-1:0] ror_0, ror_1, ror_2, ror_3;
    logic [WIDTH-1:0] shifted;
    logic             shifted_carry;
    logic             count_nonzero;

    always_comb begin
        sll_0 = {1'b0, data};
        sll_1 = shiftCount[0] ? (sll_0 << 1) : sll_0;
        sll_2 = shiftCount[1] ? (sll_1 << 2) : sll_1;
        sll_3 = shiftCount[2] ? (sll_2 << 4) : sll_2;

        srl_0 = {data, 1'b0};
        srl_1 = shiftCount[0] ? (srl_0 >> 1) : srl_0;
        srl_2 = shiftCount[1] ? (srl_1 >> 2) : srl_1;
        srl_3 = shiftCount[2] ? (srl_2 >> 4) : srl_2;

        rol_0 = data;
        rol_1 = shiftCount[0] ? {rol_0[WIDTH-2:0], rol_0[WIDTH-1]}   : rol_0;
        rol_2 = shiftCount[1] ? {rol_1[WIDTH-3:0], rol_1[WIDTH-1:WIDTH-2]} : rol_1;
        rol_3 = shiftCount[2] ? {rol_2[WIDTH-5:0], rol_2[WIDTH-1:WIDTH-4]} : rol_2;

        ror_0 = data;
        ror_1 = shiftCount[0] ? {ror_0[0],   ror_0[WIDTH-1:1]} : ror_0;
        ror_2 = shiftCount[1] ? {ror_1[1:0], ror_1[WIDTH-1:2]} : ror_1;
        ror_3 = shiftCount[2] ? {ror_2[3:0], ror_2[WIDTH-1:4]} : ror_2;
    end

    always_comb begin
        count_nonzero = (shiftCount != '0);
        shifted       = data;
        shifted_carry = 1'b0;
        case (op_e'(operation))
            OP_SLL: begin
                shifted       = sll_3[WIDTH-1:0];
                shifted_carry = sll_3[WIDTH];
            end
            OP_SRL: begin
                shifted       = srl_3[WIDTH:1];
                shifted_carry = srl_3[0];
            end
            OP_ROL: begin
                shifted       = rol_3;
                shifted_carry = count_nonzero & rol_3[0];
            end
            OP_ROR: begin
                shifted       = ror_3;
                shifted_carry = count_nonzero & ror_3[WIDTH-1];
            end
            default: begin
                shifted       = data;
                shifted_carry = 1'b0;
            end
        endcase
    end

    // Outputs hold their last values while in_valid is low.
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        valid_d  = in_valid;
        if (in_valid) begin
            result_d = shifted;
            carry_d  = shifted_carry;
            zero_d   = (shifted == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_shift_rotate.sv
// Self-checking bench for shift_rotate: directed vectors plus a random stream
// compared against an arithmetic reference model.
module tb_shift_rotate;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] shiftCount = '0;
    logic [7:0] data = '0;
    logic [1:0] operation = '0;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;
    logic       out_valid;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_result;
    logic       exp_carry;
    logic       exp_zero;
    logic       exp_valid;

    shift_rotate #(.WIDTH(8), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .shiftCount (shiftCount),
        .data       (data),
        .operation  (operation),
        .result     (result),
        .carry_out  (carry_out),
        .zero       (zero),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    // Reference computed with plain integer arithmetic on the operand.
    function automatic void refModel(input int d, input int n, input int op,
                                     output logic [7:0] r, output logic c);
        int res;
        int cy;
        res = d;
        cy  = 0;
        if (n != 0) begin
            case (op)
                0: begin res = (d << n) & 255;                 cy = (d >> (8 - n)) & 1; end
                1: begin res = d >> n;                         cy = (d >> (n - 1)) & 1; end
                2: begin res = ((d << n) | (d >> (8 - n))) & 255; cy = res & 1;        end
                default: begin res = ((d >> n) | (d << (8 - n))) & 255; cy = (res >> 7) & 1; end
            endcase
        end
        r = res[7:0];
        c = cy[0];
    endfunction

    task automatic checkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkByte({tag, ".result"}, result, exp_result);
        checkBit({tag, ".carry"}, carry_out, exp_carry);
        checkBit({tag, ".zero"}, zero, exp_zero);
        checkBit({tag, ".valid"}, out_valid, exp_valid);
    endtask

    // One clock per call: drive on the falling edge, update the model at the
    // rising edge, then check just after it.
    task automatic applyStimulus(input logic r, input logic v, input logic [2:0] n,
                                 input logic [7:0] d, input logic [1:0] op,
                                 input string tag);
        logic [7:0] mr;
        logic       mc;
        @(negedge clk);
        rst        = r;
        in_valid   = v;
        shiftCount = n;
        data       = d;
        operation  = op;
        @(posedge clk);
        if (r) begin
            exp_result = 8'h00;
            exp_carry  = 1'b0;
            exp_zero   = 1'b1;
            exp_valid  = 1'b0;
        end else begin
            exp_valid = v;
            if (v) begin
                refModel(int'(d), int'(n), int'(op), mr, mc);
                exp_result = mr;
                exp_carry  = mc;
                exp_zero   = (mr == 8'h00);
            end
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        exp_result = 8'h00;
        exp_carry  = 1'b0;
        exp_zero   = 1'b1;
        exp_valid  = 1'b0;

        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 2'b00, "reset1");
        applyStimulus(1'b1, 1'b1, 3'd2, 8'h05, 2'b00, "reset2");
        checkByte("reset_lit.result", result, 8'h00);
        checkBit("reset_lit.zero", zero, 1'b1);

        applyStimulus(1'b0, 1'b1, 3'd2, 8'h05, 2'b00, "sll_n2");
        checkByte("sll_n2_lit", result, 8'h14);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'h05, 2'b00, "sll_n3");
        checkByte("sll_n3_lit", result, 8'h28);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'h64, 2'b01, "srl_64");
        checkByte("srl_64_lit", result, 8'h0C);
        checkBit("srl_64_lit.carry", carry_out, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'd1, 8'h01, 2'b01, "srl_01");
        checkBit("srl_01_lit.zero", zero, 1'b1);
        checkBit("srl_01_lit.carry", carry_out, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'h64, 2'b10, "rol_64");
        checkByte("rol_64_lit", result, 8'h23);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'h86, 2'b10, "rol_86");
        checkByte("rol_86_lit", result, 8'h34);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'h86, 2'b11, "ror_86");
        checkByte("ror_86_lit", result, 8'hD0);
        checkBit("ror_86_lit.carry", carry_out, 1'b1);
        for (int op = 0; op < 4; op++) begin
            applyStimulus(1'b0, 1'b1, 3'd0, 8'hA5, op[1:0], "count0");
            checkByte("count0_lit", result, 8'hA5);
        end
        applyStimulus(1'b0, 1'b1, 3'd7, 8'h81, 2'b00, "sll_n7");
        applyStimulus(1'b0, 1'b1, 3'd7, 8'h81, 2'b01, "srl_n7");
        applyStimulus(1'b0, 1'b0, 3'd5, 8'hFF, 2'b10, "hold1");
        applyStimulus(1'b0, 1'b0, 3'd1, 8'h00, 2'b11, "hold2");
        applyStimulus(1'b0, 1'b1, 3'd4, 8'h3C, 2'b11, "pre_rst");
        applyStimulus(1'b1, 1'b1, 3'd4, 8'h3C, 2'b10, "rst_mid");
        checkByte("rst_mid_lit", result, 8'h00);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                          3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                          2'($urandom_range(0, 3)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
